// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the MIPS datapath.
// Owns the PC and issues one instruction-memory request at a time over a
// valid/ready channel. Each returned word is held, together with its PC, on a
// valid/ready output toward decode. A branch/jump redirect takes priority over
// every other event. If a request is still in flight when the redirect arrives,
// its response is drained and discarded.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        busy
);

  // IDLE : one-cycle start-up after reset
  // REQ  : presenting a request for the word at pc
  // WAIT : request accepted, its response will be used
  // DRAIN: request accepted but made stale by a redirect, response is dropped
  // HOLD : word presented downstream, waiting for it to be consumed
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  // Word-align any address; instruction fetches are always 4-byte aligned.
  function automatic logic [31:0] f_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Sequential PC step; the 32-bit add wraps 0xFFFFFFFC to 0x00000000.
  function automatic logic [31:0] f_pc_inc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  localparam logic [31:0] RESET_PC_A = f_align(RESET_PC);

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;

  logic [2:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_load_instr;
  logic        w_req_hs;
  logic [31:0] w_redirect_pc;

  assign w_req_hs      = (r_state == S_REQ) && imem_req_ready;
  assign w_redirect_pc = f_align(redirect_pc);

  // Next-state and next-PC selection; a redirect overrides the PC choice of every state.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_load_instr = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        // A request accepted in the same cycle as a redirect is already stale.
        if (w_req_hs) begin
          w_state_nxt = redirect_valid ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          // A response arriving with the redirect is simply not captured.
          w_state_nxt = imem_resp_valid ? S_REQ : S_DRAIN;
        end else if (imem_resp_valid) begin
          w_load_instr = 1'b1;
          w_state_nxt  = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (imem_resp_valid) begin
          w_state_nxt = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_state_nxt = S_REQ;
        end else if (instr_ready) begin
          w_pc_nxt    = f_pc_inc(r_pc);
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (redirect_valid) begin
      w_pc_nxt = w_redirect_pc;
    end
  end

  // Control state and PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC_A;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Capture the returned word with the PC it was fetched from; held stable through HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr    <= 32'd0;
      r_instr_pc <= 32'd0;
    end else if (w_load_instr) begin
      r_instr    <= imem_resp_data;
      r_instr_pc <= r_pc;
    end
  end

  // All outputs come straight from registers, so there is no combinational
  // path from instr_ready or redirect_valid to any output.
  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign busy           = (r_state == S_WAIT) || (r_state == S_DRAIN);
  assign instr_valid    = (r_state == S_HOLD);
  assign instruction    = r_instr;
  assign instr_pc       = r_instr_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit.
// Part 1 is a cycle table. Part 2 is a set of hand-written corner sequences.
// Part 3 is a randomized run: a memory model with random latency drives the
// unit, and a transaction-level PC model checks it.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        dv;
    logic [31:0] dp;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_iv;
    logic [31:0] e_in;
    logic [31:0] e_ip;
    logic        e_busy;
  } vec_t;

  vec_t tbl [19];

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", nm, act, req);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_rv, input logic [31:0] e_ra,
                          input logic e_iv, input logic [31:0] e_in, input logic [31:0] e_ip,
                          input logic e_busy);
    chk1({tag, ".req_valid"}, imem_req_valid, e_rv);
    chk32({tag, ".req_addr"}, imem_req_addr, e_ra);
    chk1({tag, ".instr_valid"}, instr_valid, e_iv);
    chk1({tag, ".busy"}, busy, e_busy);
    if (e_iv) begin
      chk32({tag, ".instruction"}, instruction, e_in);
      chk32({tag, ".instr_pc"}, instr_pc, e_ip);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, ".req_valid"}, imem_req_valid, 1'b0);
    chk32({tag, ".req_addr"}, imem_req_addr, 32'h0040_0000);
    chk1({tag, ".instr_valid"}, instr_valid, 1'b0);
    chk32({tag, ".instruction"}, instruction, 32'h0);
    chk32({tag, ".instr_pc"}, instr_pc, 32'h0);
    chk1({tag, ".busy"}, busy, 1'b0);
  endtask

  // Drive one cycle of inputs, clock once, and settle just after the edge.
  task automatic step(input logic rr_i, input logic rv_i, input logic [31:0] rd_i,
                      input logic ir_i, input logic dv_i, input logic [31:0] dp_i);
    imem_req_ready  = rr_i;
    imem_resp_valid = rv_i;
    imem_resp_data  = rd_i;
    instr_ready     = ir_i;
    redirect_valid  = dv_i;
    redirect_pc     = dp_i;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Memory contents: a bijective scramble of the address, so a word fetched
  // from the wrong address shows up as a data difference.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  logic [31:0] exp_pc;
  logic        outst;
  int          cnt;
  logic [31:0] pend;
  int          since;
  int          n_pres;
  logic        rr, rv, ir, dv;
  logic [31:0] rd, dp;

  initial begin
    // Stimulus table. Columns: inputs (rr rv rd ir dv dp), then the outputs
    // required after the edge (req_valid req_addr instr_valid instruction instr_pc busy).
    tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0000, 1'b0, 32'h0,         32'h0,         1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0000, 1'b0, 32'h0,         32'h0,         1'b1};
    tbl[2]  = '{1'b0, 1'b1, 32'h2008_0005, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0000, 1'b1, 32'h2008_0005, 32'h0040_0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0004, 1'b0, 32'h0,         32'h0,         1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0004, 1'b0, 32'h0,         32'h0,         1'b1};
    tbl[5]  = '{1'b0, 1'b1, 32'h2009_0003, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0004, 1'b1, 32'h2009_0003, 32'h0040_0004, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0008, 1'b0, 32'h0,         32'h0,         1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0008, 1'b0, 32'h0,         32'h0,         1'b1};
    tbl[8]  = '{1'b0, 1'b1, 32'h0109_5020, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0008, 1'b1, 32'h0109_5020, 32'h0040_0008, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_000C, 1'b0, 32'h0,         32'h0,         1'b0};
    tbl[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_000C, 1'b0, 32'h0,         32'h0,         1'b1};
    tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0100, 1'b0, 32'h0,         32'h0,         1'b1};
    tbl[12] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0040_0100, 1'b0, 32'h0,         32'h0,         1'b1};
    tbl[13] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0100, 1'b0, 32'h0,         32'h0,         1'b0};
    tbl[14] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0203, 1'b0, 32'h0040_0200, 1'b0, 32'h0,         32'h0,         1'b1};
    tbl[15] = '{1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0200, 1'b0, 32'h0,         32'h0,         1'b0};
    tbl[16] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0200, 1'b0, 32'h0,         32'h0,         1'b1};
    tbl[17] = '{1'b0, 1'b1, 32'h8C88_0004, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0200, 1'b1, 32'h8C88_0004, 32'h0040_0200, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0204, 1'b0, 32'h0,         32'h0,         1'b0};

    reset           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    #1;
    reset = 1'b1;
    #1;
    chk_reset_vals("reset0");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Part 1: in-order fetch, redirect in WAIT, redirect on the handshake.
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rr, tbl[i].rv, tbl[i].rd, tbl[i].ir, tbl[i].dv, tbl[i].dp);
      chk_outs($sformatf("tbl.row%0d", i), tbl[i].e_rv, tbl[i].e_ra, tbl[i].e_iv,
               tbl[i].e_in, tbl[i].e_ip, tbl[i].e_busy);
    end

    // Part 2a: backpressure in HOLD, including a stray response that must be ignored.
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h3C0F_92C3, 1'b0, 1'b0, 32'h0);
    chk_outs("bp.present", 1'b0, 32'h0040_0000, 1'b1, 32'h3C0F_92C3, 32'h0040_0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, (k == 2), 32'hFFFF_0000, 1'b0, 1'b0, 32'h0);
      chk_outs($sformatf("bp.hold%0d", k), 1'b0, 32'h0040_0000, 1'b1, 32'h3C0F_92C3,
               32'h0040_0000, 1'b0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_outs("bp.release", 1'b1, 32'h0040_0004, 1'b0, 32'h0, 32'h0, 1'b0);

    // Part 2b: redirect while HOLD with instr_ready low.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
    chk_outs("rh.present", 1'b0, 32'h0040_0004, 1'b1, 32'h1111_1111, 32'h0040_0004, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0400);
    chk_outs("rh.redirect", 1'b1, 32'h0040_0400, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
    chk_outs("rh.target", 1'b0, 32'h0040_0400, 1'b1, 32'h2222_2222, 32'h0040_0400, 1'b0);

    // Part 2c: redirect to the top word, PC wrap, then async reset while in WAIT.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_outs("wr.req", 1'b1, 32'h0040_0404, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk_outs("wr.redirect", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
    chk_outs("wr.present", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h3333_3333, 32'hFFFF_FFFC, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_outs("wr.wrap", 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk_outs("ar.wait", 1'b0, 32'h0000_0000, 1'b0, 32'h0, 32'h0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("ar.async");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Part 3: random traffic against the memory and PC models.
    do_reset();
    exp_pc = 32'h0040_0000;
    outst  = 1'b0;
    cnt    = 0;
    pend   = 32'h0;
    since  = 0;
    n_pres = 0;
    for (int c = 0; c < 3000; c++) begin
      chk1("rnd.busy", busy, outst);
      if (instr_valid) begin
        chk32("rnd.instr_pc", instr_pc, exp_pc);
        chk32("rnd.instruction", instruction, mem_word(exp_pc));
        n_pres++;
        since = 0;
      end else begin
        since++;
      end
      if (since > 300) begin
        chk32("rnd.progress_timeout", since, 32'd0);
        break;
      end

      rr = ($urandom_range(0, 3) != 0);
      if (outst && cnt == 0) begin
        rv = 1'b1;
        rd = pend;
      end else begin
        rv = 1'b0;
        rd = $urandom;
        if (outst) cnt--;
      end
      ir = ($urandom_range(0, 2) != 0);
      dv = ($urandom_range(0, 15) == 0);
      dp = 32'h0040_0000 + ($urandom & 32'h0000_03FF);
      if ($urandom_range(0, 7) == 0) dp = 32'hFFFF_FFF8 | ($urandom & 32'h7);

      if (imem_req_valid && rr) begin
        chk32("rnd.req_addr", imem_req_addr, exp_pc);
        chk1("rnd.one_outstanding", outst, 1'b0);
      end
      if (rv) outst = 1'b0;
      if (imem_req_valid && rr) begin
        outst = 1'b1;
        cnt   = $urandom_range(0, 3);
        pend  = mem_word(imem_req_addr);
      end
      if (dv) exp_pc = dp & 32'hFFFF_FFFC;
      else if (instr_valid && ir) exp_pc = exp_pc + 32'd4;

      step(rr, rv, rd, ir, dv, dp);
    end
    chk1("rnd.presented_some", (n_pres > 0), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
